// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR pseudo-random generator family:
// mode encodings and default maximal-length tap masks.
package lfsr_pkg;

  localparam logic [1:0] MODE_RUN   = 2'b00;
  localparam logic [1:0] MODE_SHIFT = 2'b01;
  localparam logic [1:0] MODE_LOAD  = 2'b10;
  localparam logic [1:0] MODE_HOLD  = 2'b11;

  localparam logic [7:0]  TAPS_8  = 8'hB8;
  localparam logic [15:0] TAPS_16 = 16'hB400;
  localparam logic [31:0] TAPS_32 = 32'hA300_0000;

endpackage

// File: rtl/lfsr_feedback.sv
// Combinational Fibonacci feedback: XOR-reduce of the tapped state bits,
// plus an all-zero detect used for the lock-up escape.
module lfsr_feedback #(
  parameter int                WIDTH = 32,
  parameter logic [WIDTH-1:0]  TAPS  = WIDTH'(32'hA300_0000)
) (
  input  logic [WIDTH-1:0] state,
  output logic             fb_xor,
  output logic             is_zero
);

  assign fb_xor  = ^(state & TAPS);
  assign is_zero = (state == '0);

endmodule

// File: rtl/lfsr_prng_core.sv
// Parametrised Fibonacci LFSR with serial shift-in, parallel load, hold,
// step counter, zero-escape pulse and period-detect pulse.
module lfsr_prng_core
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 32,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(TAPS_32),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(32'h0000_0001),
  parameter int               OUT_W = 8,
  parameter int               CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             ser_in,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] state,
  output logic [OUT_W-1:0] out_word,
  output logic             ser_out,
  output logic             zero_fix,
  output logic             period_done,
  output logic [CNT_W-1:0] step_cnt
);

  if (OUT_W > WIDTH) begin : g_bad_out_w
    $error("lfsr_prng_core: OUT_W must not exceed WIDTH");
  end
  if (TAPS[WIDTH-1] == 1'b0) begin : g_bad_taps
    $error("lfsr_prng_core: TAPS must include the top state bit");
  end
  if (WIDTH < 4 || WIDTH > 64) begin : g_bad_width
    $error("lfsr_prng_core: WIDTH must be in 4..64");
  end

  logic [WIDTH-1:0] state_q, state_d;
  logic [WIDTH-1:0] seed_ref_q, seed_ref_d;
  logic [CNT_W-1:0] step_cnt_q, step_cnt_d;
  logic             zero_fix_q, zero_fix_d;
  logic             period_done_q, period_done_d;
  logic             fb_xor, is_zero;
  logic [WIDTH-1:0] run_next;

  lfsr_feedback #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS)
  ) u_feedback (
    .state   (state_q),
    .fb_xor  (fb_xor),
    .is_zero (is_zero)
  );

  // The zero term forces a 1 in, so the all-zero lock-up state steps to 1.
  assign run_next = {state_q[WIDTH-2:0], fb_xor | is_zero};

  always_comb begin
    state_d       = state_q;
    seed_ref_d    = seed_ref_q;
    step_cnt_d    = step_cnt_q;
    zero_fix_d    = 1'b0;
    period_done_d = 1'b0;
    if (en) begin
      case (mode)
        MODE_RUN: begin
          state_d       = run_next;
          step_cnt_d    = step_cnt_q + CNT_W'(1);
          zero_fix_d    = is_zero;
          period_done_d = (run_next == seed_ref_q);
        end
        MODE_SHIFT: begin
          state_d    = {state_q[WIDTH-2:0], ser_in};
          step_cnt_d = step_cnt_q + CNT_W'(1);
        end
        MODE_LOAD: begin
          state_d    = load_val;
          seed_ref_d = load_val;
          step_cnt_d = '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= SEED;
      seed_ref_q    <= SEED;
      step_cnt_q    <= '0;
      zero_fix_q    <= 1'b0;
      period_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      seed_ref_q    <= seed_ref_d;
      step_cnt_q    <= step_cnt_d;
      zero_fix_q    <= zero_fix_d;
      period_done_q <= period_done_d;
    end
  end

  assign state       = state_q;
  assign out_word    = state_q[WIDTH-1 -: OUT_W];
  assign ser_out     = state_q[WIDTH-1];
  assign zero_fix    = zero_fix_q;
  assign period_done = period_done_q;
  assign step_cnt    = step_cnt_q;

endmodule

// File: tb/tb_lfsr_prng_core.sv
// Directed and randomised checks of lfsr_prng_core: a 32-bit default instance
// against hand-computed vectors and a reference model, and a 4-bit instance for period detect.
module tb_lfsr_prng_core;
  import lfsr_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en, ser_in;
  logic [1:0]  mode;
  logic [31:0] load_val;
  logic [31:0] state;
  logic [7:0]  out_word;
  logic        ser_out, zero_fix, period_done;
  logic [31:0] step_cnt;

  logic        rst4, en4, ser4;
  logic [1:0]  mode4;
  logic [3:0]  load4, state4;
  logic [1:0]  out_word4;
  logic        ser_out4, zero_fix4, period_done4;
  logic [7:0]  step_cnt4;

  lfsr_prng_core u_dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .mode        (mode),
    .ser_in      (ser_in),
    .load_val    (load_val),
    .state       (state),
    .out_word    (out_word),
    .ser_out     (ser_out),
    .zero_fix    (zero_fix),
    .period_done (period_done),
    .step_cnt    (step_cnt)
  );

  lfsr_prng_core #(
    .WIDTH (4),
    .TAPS  (4'hC),
    .SEED  (4'h1),
    .OUT_W (2),
    .CNT_W (8)
  ) u_dut4 (
    .clk         (clk),
    .rst         (rst4),
    .en          (en4),
    .mode        (mode4),
    .ser_in      (ser4),
    .load_val    (load4),
    .state       (state4),
    .out_word    (out_word4),
    .ser_out     (ser_out4),
    .zero_fix    (zero_fix4),
    .period_done (period_done4),
    .step_cnt    (step_cnt4)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Reference model of the 32-bit instance, written bit-serially.
  localparam logic [31:0] M_TAPS = 32'hA300_0000;
  localparam logic [31:0] M_SEED = 32'h0000_0001;
  logic [31:0] m_state, m_seed, m_cnt;
  logic        m_zf, m_pd;
  logic [31:0] exp_q[$];

  task automatic model_step(input logic r, input logic e, input logic [1:0] md,
                            input logic s, input logic [31:0] lv);
    logic        fb;
    logic [31:0] nxt;
    if (r) begin
      m_state = M_SEED; m_seed = M_SEED; m_cnt = 0; m_zf = 1'b0; m_pd = 1'b0;
    end else begin
      m_zf = 1'b0;
      m_pd = 1'b0;
      if (e) begin
        if (md == MODE_RUN) begin
          fb = 1'b0;
          for (int i = 0; i < 32; i++) if (M_TAPS[i]) fb = fb ^ m_state[i];
          if (m_state == 32'h0) begin
            fb   = 1'b1;
            m_zf = 1'b1;
          end
          nxt     = (m_state << 1) | {31'h0, fb};
          m_pd    = (nxt == m_seed);
          m_state = nxt;
          m_cnt   = m_cnt + 1;
        end else if (md == MODE_SHIFT) begin
          m_state = (m_state << 1) | {31'h0, s};
          m_cnt   = m_cnt + 1;
        end else if (md == MODE_LOAD) begin
          m_state = lv; m_seed = lv; m_cnt = 0;
        end
      end
    end
  endtask

  // ---------------- driver ----------------
  // Apply inputs, clock once, update the model, sample 1 time unit after the edge.
  task automatic drive_cycle(input logic r, input logic e, input logic [1:0] md,
                             input logic s, input logic [31:0] lv);
    rst = r; en = e; mode = md; ser_in = s; load_val = lv;
    @(posedge clk);
    model_step(r, e, md, s, lv);
    #1;
  endtask

  task automatic check_vs_model(input string tag);
    check({tag, ".state"},  64'(state),       64'(m_state));
    check({tag, ".cnt"},    64'(step_cnt),    64'(m_cnt));
    check({tag, ".zf"},     64'(zero_fix),    64'(m_zf));
    check({tag, ".pd"},     64'(period_done), 64'(m_pd));
    check({tag, ".out"},    64'(out_word),    64'(m_state[31:24]));
  endtask

  initial begin
    logic       zf_seen;
    int         pulses;
    logic [1:0] rmode;

    rst = 1'b1; en = 1'b0; mode = MODE_HOLD; ser_in = 1'b0; load_val = '0;
    rst4 = 1'b1; en4 = 1'b0; mode4 = MODE_HOLD; ser4 = 1'b0; load4 = '0;
    m_state = '0; m_seed = '0; m_cnt = '0; m_zf = 1'b0; m_pd = 1'b0;

    // 1. reset, 24 RUN steps, then the first tap feeds back
    drive_cycle(1'b1, 1'b0, MODE_HOLD, 1'b0, 32'h0);
    check("rst.state", 64'(state), 64'(32'h1));
    check("rst.cnt",   64'(step_cnt), 64'(0));
    check("rst.pulse", 64'({zero_fix, period_done}), 64'(0));
    for (int i = 0; i < 24; i++) drive_cycle(1'b0, 1'b1, MODE_RUN, 1'b0, 32'h0);
    check("run24.state", 64'(state), 64'(32'h0100_0000));
    check("run24.cnt",   64'(step_cnt), 64'(24));
    check("run24.ser_out", 64'(ser_out), 64'(0));
    drive_cycle(1'b0, 1'b1, MODE_RUN, 1'b0, 32'h0);
    check("run25.state", 64'(state), 64'(32'h0200_0001));

    // 2. zero escape
    drive_cycle(1'b0, 1'b1, MODE_LOAD, 1'b0, 32'h0);
    check("load0.state", 64'(state), 64'(0));
    check("load0.cnt",   64'(step_cnt), 64'(0));
    drive_cycle(1'b0, 1'b1, MODE_RUN, 1'b0, 32'h0);
    check("esc.state", 64'(state), 64'(32'h1));
    check("esc.zf",    64'(zero_fix), 64'(1));
    drive_cycle(1'b0, 1'b1, MODE_RUN, 1'b0, 32'h0);
    check("esc2.state", 64'(state), 64'(32'h2));
    check("esc2.zf",    64'(zero_fix), 64'(0));

    // 3. serial shift-in of ones, no zero escape
    drive_cycle(1'b0, 1'b1, MODE_LOAD, 1'b0, 32'h0);
    zf_seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive_cycle(1'b0, 1'b1, MODE_SHIFT, 1'b1, 32'h0);
      zf_seen = zf_seen | zero_fix;
    end
    check("shift.state", 64'(state), 64'(32'hFF));
    check("shift.out",   64'(out_word), 64'(8'h00));
    check("shift.cnt",   64'(step_cnt), 64'(8));
    check("shift.zf",    64'(zf_seen), 64'(0));

    // 4. hold / disable mid-RUN, then reset beating LOAD
    for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b1, MODE_RUN, 1'b0, 32'h0);
    check("run3.state", 64'(state), 64'(32'h7F8));
    for (int i = 0; i < 5; i++) begin
      if (i < 3) drive_cycle(1'b0, 1'b0, MODE_RUN, 1'b1, 32'h1234);
      else       drive_cycle(1'b0, 1'b1, MODE_HOLD, 1'b1, 32'h1234);
      check("hold.state", 64'(state), 64'(32'h7F8));
      check("hold.cnt",   64'(step_cnt), 64'(11));
      check("hold.pulse", 64'({zero_fix, period_done}), 64'(0));
    end
    drive_cycle(1'b1, 1'b1, MODE_LOAD, 1'b0, 32'hDEAD_BEEF);
    check("rstload.state", 64'(state), 64'(32'h1));
    check("rstload.cnt",   64'(step_cnt), 64'(0));

    // 5. 4-bit instance: period of 15
    drive_cycle(1'b0, 1'b0, MODE_HOLD, 1'b0, 32'h0);
    check("w4.rst.state", 64'(state4), 64'(4'h1));
    rst4 = 1'b0; en4 = 1'b1; mode4 = MODE_RUN;
    pulses = 0;
    for (int step = 1; step <= 45; step++) begin
      drive_cycle(1'b0, 1'b0, MODE_HOLD, 1'b0, 32'h0);
      if (step % 15 == 0) begin
        check("w4.pd",    64'(period_done4), 64'(1));
        check("w4.state", 64'(state4), 64'(4'h1));
        check("w4.cnt",   64'(step_cnt4), 64'(step));
      end
      if (period_done4) pulses++;
    end
    check("w4.pulses", 64'(pulses), 64'(3));
    en4 = 1'b0;

    // 6. random mix against the reference model
    for (int i = 0; i < 10000; i++) begin
      rmode = 2'($urandom_range(0, 3));
      drive_cycle(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) != 0), rmode,
                  1'($urandom_range(0, 1)),
                  ($urandom_range(0, 15) == 0) ? 32'h0 : 32'($urandom));
      exp_q.push_back(m_state);
      check_vs_model("rnd");
      void'(exp_q.pop_front());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
